// File: rtl/idp_ctrl_pkg.sv
// Shared definitions for the integer data path control unit: FSM states,
// instruction field positions, condition codes and status bit indices.
package idp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IMM  = 2'd1,
        ST_EXEC = 2'd2
    } idpc_state_e;

    localparam int FLD_OP_LSB  = 12;
    localparam int FLD_W_LSB   = 9;
    localparam int FLD_R_LSB   = 6;
    localparam int FLD_S_LSB   = 3;
    localparam int FLD_IMM_BIT = 2;
    localparam int FLD_CND_LSB = 0;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b01;
    localparam logic [1:0] COND_N      = 2'b10;
    localparam logic [1:0] COND_C      = 2'b11;

    localparam int ST_C_BIT = 2;
    localparam int ST_N_BIT = 1;
    localparam int ST_Z_BIT = 0;

    // True when the instruction condition holds against the current flags.
    function automatic logic cond_pass(input logic [1:0] cond, input logic [2:0] flags);
        logic ok;
        case (cond)
            COND_ALWAYS: ok = 1'b1;
            COND_Z:      ok = flags[ST_Z_BIT];
            COND_N:      ok = flags[ST_N_BIT];
            COND_C:      ok = flags[ST_C_BIT];
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/idp_status_reg.sv
// C/N/Z status flag register with load enable and asynchronous active-low clear.
module idp_status_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] d,
    output logic [2:0] q
);

    // Flag storage, updated only on an executed instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 3'b000;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/idp_control_unit.sv
// Instruction sequencing/decode stage for the integer data path.
// Optional conditional execution is enabled by defining IDPC_COND_EXEC_EN.
module idp_control_unit
    import idp_ctrl_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] instr_in,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic          C_in,
    input  logic          N_in,
    input  logic          Z_in,
    output logic          W_En,
    output logic [AW-1:0] W_Adr,
    output logic [AW-1:0] R_Adr,
    output logic [AW-1:0] S_Adr,
    output logic          S_Sel,
    output logic [3:0]    ALU_OP,
    output logic [DW-1:0] DS,
    output logic [2:0]    status,
    output logic          done
);

`ifdef IDPC_COND_EXEC_EN
    localparam bit COND_EN = 1'b1;
`else
    localparam bit COND_EN = 1'b0;
`endif

    idpc_state_e   state_r, state_next_s;
    logic [DW-1:0] instr_r;
    logic [DW-1:0] imm_r;
    logic          exec_s;
    logic          imm_flag_s;
    logic          cond_ok_s;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a word is only ever accepted in IDLE or IMM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid) begin
                    state_next_s = instr_in[FLD_IMM_BIT] ? ST_IMM : ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_IMM: begin
                if (instr_valid) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IMM;
                end
            end
            ST_EXEC: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Instruction and immediate capture; reset discards anything pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_r <= {DW{1'b0}};
            imm_r   <= {DW{1'b0}};
        end else begin
            if (state_r == ST_IDLE && instr_valid) begin
                instr_r <= instr_in;
            end
            if (state_r == ST_IMM && instr_valid) begin
                imm_r <= instr_in;
            end
        end
    end

    assign exec_s     = (state_r == ST_EXEC);
    assign imm_flag_s = instr_r[FLD_IMM_BIT];
    // The condition is judged against the flags as they stood before this EXEC.
    assign cond_ok_s  = !COND_EN || cond_pass(instr_r[FLD_CND_LSB +: 2], status);

    assign instr_ready = !exec_s;
    assign done        = exec_s;
    assign W_En        = exec_s && cond_ok_s;
    assign S_Sel       = exec_s && imm_flag_s;
    assign DS          = (exec_s && imm_flag_s) ? imm_r : {DW{1'b0}};
    assign ALU_OP      = instr_r[FLD_OP_LSB +: 4];
    assign W_Adr       = instr_r[FLD_W_LSB +: AW];
    assign R_Adr       = instr_r[FLD_R_LSB +: AW];
    assign S_Adr       = instr_r[FLD_S_LSB +: AW];

    idp_status_reg u_status (
        .clk   (clk),
        .rst_n (reset),
        .load  (W_En),
        .d     ({C_in, N_in, Z_in}),
        .q     (status)
    );

endmodule

// File: tb/tb_idp_control_unit.sv
// Directed, table-driven bench for idp_control_unit (default or IDPC_COND_EXEC_EN build).
module tb_idp_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instr_in = 16'h0000;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        C_in = 1'b0, N_in = 1'b0, Z_in = 1'b0;
    logic        W_En, S_Sel, done;
    logic [2:0]  W_Adr, R_Adr, S_Adr, status;
    logic [3:0]  ALU_OP;
    logic [15:0] DS;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] instr;
        logic        use_imm;
        logic [15:0] imm;
        logic [2:0]  flags;
        logic        exp_wen;
        logic [3:0]  exp_op;
        logic [2:0]  exp_w, exp_r, exp_s;
        logic        exp_ssel;
        logic [15:0] exp_ds;
        logic [2:0]  exp_status;
    } vec_t;

    vec_t vecs[7];

    idp_control_unit #(.DW(16), .AW(3)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .C_in(C_in), .N_in(N_in), .Z_in(Z_in),
        .W_En(W_En), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr), .S_Sel(S_Sel),
        .ALU_OP(ALU_OP), .DS(DS), .status(status), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, " ready"}, {31'd0, instr_ready}, 32'd1);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " wen"}, {31'd0, W_En}, 32'd0);
        chk({tag, " ssel"}, {31'd0, S_Sel}, 32'd0);
        chk({tag, " ds"}, {16'd0, DS}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'h3298, 1'b0, 16'h0000, 3'b101, 1'b1, 4'h3, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000, 3'b101};
        vecs[1] = '{16'h1204, 1'b1, 16'hBEEF, 3'b010, 1'b1, 4'h1, 3'd1, 3'd0, 3'd0, 1'b1, 16'hBEEF, 3'b010};
`ifdef IDPC_COND_EXEC_EN
        vecs[2] = '{16'hA5ED, 1'b1, 16'h1234, 3'b000, 1'b0, 4'hA, 3'd2, 3'd7, 3'd5, 1'b1, 16'h1234, 3'b010};
        vecs[4] = '{16'h0001, 1'b0, 16'h0000, 3'b001, 1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 3'b110};
`else
        vecs[2] = '{16'hA5ED, 1'b1, 16'h1234, 3'b000, 1'b1, 4'hA, 3'd2, 3'd7, 3'd5, 1'b1, 16'h1234, 3'b000};
        vecs[4] = '{16'h0001, 1'b0, 16'h0000, 3'b001, 1'b1, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 3'b001};
`endif
        vecs[3] = '{16'hFFFA, 1'b0, 16'h0000, 3'b110, 1'b1, 4'hF, 3'd7, 3'd7, 3'd7, 1'b0, 16'h0000, 3'b110};
        vecs[5] = '{16'h0003, 1'b0, 16'h0000, 3'b001, 1'b1, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 3'b001};
        vecs[6] = '{16'h0001, 1'b0, 16'h0000, 3'b111, 1'b1, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 3'b111};

        // Reset held with a valid word: nothing may transfer.
        instr_in = 16'h3298;
        instr_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            idle_chk("rst");
            chk("rst status", {29'd0, status}, 32'd0);
            chk("rst wadr", {29'd0, W_Adr}, 32'd0);
            chk("rst op", {28'd0, ALU_OP}, 32'd0);
            cyc();
        end
        instr_valid = 1'b0;
        reset = 1'b1;
        cyc();
        idle_chk("post rst");

`ifdef IDPC_COND_EXEC_EN
        // COND=01 with Z clear: EXEC runs but without write or flag update.
        instr_in = 16'h0001;
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        {C_in, N_in, Z_in} = 3'b111;
        chk("cond fail done", {31'd0, done}, 32'd1);
        chk("cond fail wen", {31'd0, W_En}, 32'd0);
        cyc();
        chk("cond fail status", {29'd0, status}, 32'd0);
        idle_chk("cond fail idle");
`endif

        for (int v = 0; v < 7; v++) begin
            chk($sformatf("v%0d ready", v), {31'd0, instr_ready}, 32'd1);
            instr_in = vecs[v].instr;
            instr_valid = 1'b1;
            cyc();
            if (vecs[v].use_imm) begin
                chk($sformatf("v%0d imm ready", v), {31'd0, instr_ready}, 32'd1);
                chk($sformatf("v%0d imm wen", v), {31'd0, W_En}, 32'd0);
                instr_in = vecs[v].imm;
                cyc();
            end
            instr_valid = 1'b0;
            {C_in, N_in, Z_in} = vecs[v].flags;
            chk($sformatf("v%0d done", v), {31'd0, done}, 32'd1);
            chk($sformatf("v%0d exec ready", v), {31'd0, instr_ready}, 32'd0);
            chk($sformatf("v%0d wen", v), {31'd0, W_En}, {31'd0, vecs[v].exp_wen});
            chk($sformatf("v%0d op", v), {28'd0, ALU_OP}, {28'd0, vecs[v].exp_op});
            chk($sformatf("v%0d wadr", v), {29'd0, W_Adr}, {29'd0, vecs[v].exp_w});
            chk($sformatf("v%0d radr", v), {29'd0, R_Adr}, {29'd0, vecs[v].exp_r});
            chk($sformatf("v%0d sadr", v), {29'd0, S_Adr}, {29'd0, vecs[v].exp_s});
            chk($sformatf("v%0d ssel", v), {31'd0, S_Sel}, {31'd0, vecs[v].exp_ssel});
            chk($sformatf("v%0d ds", v), {16'd0, DS}, {16'd0, vecs[v].exp_ds});
            cyc();
            chk($sformatf("v%0d status", v), {29'd0, status}, {29'd0, vecs[v].exp_status});
            idle_chk($sformatf("v%0d idle", v));
            chk($sformatf("v%0d hold op", v), {28'd0, ALU_OP}, {28'd0, vecs[v].exp_op});
        end

        // Immediate arrives late: unit waits in IMM; then a word held through EXEC.
        instr_in = 16'h1204;
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle_chk($sformatf("imm wait%0d", i));
            cyc();
        end
        instr_in = 16'h0055;
        instr_valid = 1'b1;
        cyc();
        chk("late imm done", {31'd0, done}, 32'd1);
        chk("late imm ds", {16'd0, DS}, 32'h0055);
        chk("late imm ssel", {31'd0, S_Sel}, 32'd1);
        instr_in = 16'h3298;
        {C_in, N_in, Z_in} = 3'b101;
        cyc();
        idle_chk("held word idle");
        chk("held word op", {28'd0, ALU_OP}, 32'd1);
        cyc();
        instr_valid = 1'b0;
        chk("held word done", {31'd0, done}, 32'd1);
        chk("held word wadr", {29'd0, W_Adr}, 32'd1);
        chk("held word radr", {29'd0, R_Adr}, 32'd2);
        {C_in, N_in, Z_in} = 3'b111;
        cyc();
        chk("pre abort status", {29'd0, status}, 32'd7);

        // Asynchronous reset in the middle of EXEC.
        instr_in = 16'h3298;
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        chk("abort wen before", {31'd0, W_En}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort wen", {31'd0, W_En}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort status", {29'd0, status}, 32'd0);
        chk("abort wadr", {29'd0, W_Adr}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        idle_chk("after abort");
        chk("after abort status", {29'd0, status}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idp_control_unit.md
# idp_control_unit

Sequencing control stage placed directly upstream of the integer data path. It accepts 16-bit instruction words over a valid/ready handshake, plus an optional immediate word, and decodes them into the data path control word: write enable, three register addresses, S-operand select, ALU opcode and immediate data. It captures the data path's C/N/Z flags into a status register after every executed instruction.

## Interface
Parameters:
- `DW`, 16, instruction, immediate and `DS` width.
- `AW`, 3, register address width (8 registers).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 = reset asserted.
- `instr_in`  in  DW  instruction word, or immediate word when in IMM.
- `instr_valid`  in  1  `instr_in` is valid.
- `instr_ready`  out  1  unit can accept a word this cycle.
- `C_in`, `N_in`, `Z_in`  in  1 each  flags from the data path ALU, sampled during EXEC.
- `W_En`  out  1  register-file write enable.
- `W_Adr`, `R_Adr`, `S_Adr`  out  AW each  write, R-port and S-port addresses.
- `S_Sel`  out  1  1 selects `DS` as the S operand; 0 selects the register S port.
- `ALU_OP`  out  4  ALU opcode.
- `DS`  out  DW  immediate data.
- `status`  out  3  registered flags {C,N,Z}.
- `done`  out  1  high for exactly the EXEC cycle.

## Operation
- Instruction fields: [15:12] ALU_OP, [11:9] W_Adr, [8:6] R_Adr, [5:3] S_Adr, [2] IMM, [1:0] COND.
- Handshake: a word transfers on a rising edge where `instr_valid` and `instr_ready` are both 1. The upstream side holds `instr_in` stable until that edge.
- State machine has three states: IDLE, IMM, EXEC.
  - IDLE: `instr_ready`=1. On transfer, the instruction is latched. Next state is IMM if IMM=1, otherwise EXEC.
  - IMM: `instr_ready`=1. On transfer, the word is latched into the immediate register and the next state is EXEC. Otherwise the unit stays in IMM indefinitely.
  - EXEC: `instr_ready`=0 and `done`=1. Outputs:
    - `W_En`=1, subject to COND.
    - Addresses and `ALU_OP` come from the latched instruction.
    - `S_Sel`=IMM.
    - `DS` = the immediate register if IMM=1, otherwise 0.
  - At the end of EXEC, `status` is loaded with {C_in,N_in,Z_in}, subject to COND, and the state returns to IDLE.
- Outside EXEC: `W_En`=0, `S_Sel`=0, `DS`=0. Addresses and `ALU_OP` hold their last latched values.
- Writes and flag capture happen on the same edge that ends EXEC. A following instruction therefore sees the updated register and `status`.
- Reset values: state IDLE. `W_En`, `S_Sel`, `DS`, `W_Adr`, `R_Adr`, `S_Adr`, `ALU_OP`, `status`, `done` are all 0. `instr_ready`=1.
- Reset asserted mid-operation: the state goes to IDLE immediately (asynchronously), `W_En` drops to 0 with no write, any pending instruction or immediate is discarded, and `status` is cleared.
- A word presented while the unit is in EXEC is not accepted. It must be held until IDLE.

## Timing
- Non-immediate instruction: accepted at edge N, EXEC during cycle N+1, back in IDLE at N+2. Throughput is one instruction per 2 cycles.
- Immediate instruction: instruction accepted at edge N. If the immediate is offered back-to-back, it is accepted at N+1, EXEC runs during cycle N+2, and throughput is one instruction per 3 cycles.
- All outputs are registered or decoded purely from state. There is no combinational path from `instr_in`/`instr_valid` to any output.

## Configuration
- `IDPC_COND_EXEC_EN` defined: COND controls conditional execution, using `status` as it stood before EXEC.
  - 00: always execute.
  - 01: execute if Z=1.
  - 10: execute if N=1.
  - 11: execute if C=1.
  - When the condition fails, EXEC still lasts one cycle with `done`=1, but `W_En`=0 and `status` is unchanged.
- `IDPC_COND_EXEC_EN` undefined: COND bits are ignored and every instruction executes.

## Structure
- Shared package `idp_ctrl_pkg` holds:
  - the state encoding enum (IDLE, IMM, EXEC);
  - instruction field position constants;
  - COND code constants;
  - the `status` bit indices.
- One sub-module is natural: `idp_status_reg`, the flag register with load enable and async active-low clear.
- Decode and FSM stay in the top module.

## Test plan
- Reset with `instr_valid`=1 → all outputs 0, `instr_ready`=1; no transfer until `reset` goes to 1.
- Instruction 16'h3298, i.e. ALU_OP=3, W=1, R=2, S=3, IMM=0 → one cycle later `W_En`=1, `W_Adr`=1, `R_Adr`=2, `S_Adr`=3, `ALU_OP`=3, `S_Sel`=0, `done`=1; `instr_ready` returns to 1 the cycle after.
- Instruction 16'h1204 (IMM=1), then immediate 16'hBEEF one cycle later → EXEC one cycle after the immediate transfer with `S_Sel`=1 and `DS`=16'hBEEF. A second immediate-bit word delayed 3 cycles keeps the unit in IMM with `W_En`=0 throughout.
- `C_in`/`N_in`/`Z_in` = 1/0/1 during EXEC → `status`=3'b101 on the following cycle.
- With `IDPC_COND_EXEC_EN` defined, `status`=3'b000 and COND=01 → `done`=1, `W_En`=0, `status` stays 0. With `status` Z=1 → `W_En`=1.
- Deassert `reset` to 0 during EXEC → `W_En` goes low asynchronously, `status`=0, and the unit is back in IDLE after release.
